// File: rtl/div_ctrl_if.sv
// div_ctrl_if: operand/result bus between div_ctrl and the
// shared unsigned divider (start pulse, busy flag, results).
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    output dividend, divisor, start,
    input  busy, q, r
  );

  modport slave (
    input  dividend, divisor, start,
    output busy, q, r
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU through the shared divider,
// applies sign fix-up and owns the HI/LO registers.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  div_ctrl_if.master       dv
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] FIX   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]       state;
  logic             sq;
  logic             sr;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             accept;
  logic             in_flight;

  function automatic logic [WIDTH-1:0] neg(
    input logic [WIDTH-1:0] x
  );
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x,
    input logic             s
  );
    return (s & x[WIDTH-1]) ? neg(x) : x;
  endfunction

  // Decode which states accept work and which hold the pipe.
  always_comb begin
    accept    = (state == IDLE) || (state == DONE);
    in_flight = (state == START) || (state == WAIT) ||
                (state == RUN)   || (state == FIX);
  end

  // Stall is combinational so the op's own cycle is held.
  always_comb begin
    stall = ~reset &
            (in_flight | (accept & op_valid & (|rt_val)));
  end

  assign done        = (state == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dv.dividend = dvd;
  assign dv.divisor  = dvs;
  assign dv.start    = (state == START);

  // Sequencer, operand latches and HI/LO update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sq    <= 1'b0;
      sr    <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept) begin
      if (op_valid) begin
        sq <= op_signed &
              (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        sr <= op_signed & rs_val[WIDTH-1];
        if (|rt_val) begin
          dvd   <= mag(rs_val, op_signed);
          dvs   <= mag(rt_val, op_signed);
          state <= START;
        end else begin
          lo_q  <= '1;
          hi_q  <= rs_val;
          state <= DONE;
        end
      end else begin
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
        state <= IDLE;
      end
    end else begin
      unique case (state)
        START: state <= WAIT;
        WAIT:  if (dv.busy) state <= RUN;
        RUN:   if (!dv.busy) state <= FIX;
        FIX: begin
          lo_q  <= sq ? neg(dv.q) : dv.q;
          hi_q  <= sr ? neg(dv.r) : dv.r;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a
// behavioural multi-cycle divider on the slave side.
module tb_div_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  div_ctrl_if dv ();

  div_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_signed (op_signed),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dv        (dv.master)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          errors = 0;
  int          start_cnt = 0;
  logic [63:0] exp_q[$];
  int          cnt = 0;

  // Divider model: busy for a random span after start.
  always @(posedge clock) begin
    if (reset) begin
      dv.busy <= 1'b0;
      dv.q    <= '0;
      dv.r    <= '0;
      cnt     <= 0;
    end else if (dv.start) begin
      dv.busy <= 1'b1;
      cnt     <= int'($urandom_range(1, 6));
      if (dv.divisor != 0) begin
        dv.q <= dv.dividend / dv.divisor;
        dv.r <= dv.dividend % dv.divisor;
      end else begin
        dv.q <= '1;
        dv.r <= dv.dividend;
      end
    end else if (dv.busy) begin
      if (cnt <= 1) dv.busy <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  // Reference: 64-bit arithmetic, no overflow cases.
  function automatic logic [63:0] ref_div(
    input bit s, input logic [31:0] a, input logic [31:0] b
  );
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Scoreboard: pop and compare whenever done pulses.
  always @(negedge clock) begin
    if (dv.start) start_cnt++;
    if (!reset && done) begin
      logic [63:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected done hi=%h lo=%h",
                 hi, lo);
      end else begin
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          errors++;
          $display("FAIL result: hi=%h lo=%h want hi=%h lo=%h",
                   hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic drive_op(
    input bit s, input logic [31:0] a, input logic [31:0] b
  );
    op_valid  = 1'b1;
    op_signed = s;
    rs_val    = a;
    rt_val    = b;
    exp_q.push_back(ref_div(s, a, b));
    #1;
    vectors++;
    if (stall !== (b != 0)) begin
      errors++;
      $display("FAIL op_stall: stall=%b want %b",
               stall, (b != 0));
    end
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    rs_val   = '0;
    rt_val   = '0;
  endtask

  task automatic wait_done(output bit sok);
    bit got;
    sok = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        if (stall !== 1'b0) sok = 1'b0;
        break;
      end
      if (stall !== 1'b1) sok = 1'b0;
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: done=%b want 1", done);
    end
  endtask

  task automatic wait_busy();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dv.busy) begin
        got = 1'b1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL busy_timeout: busy=%b want 1", dv.busy);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    op_valid = 1'b1;
    rt_val   = 32'd1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: stall=%b want 0", stall);
    end
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({hi, lo, done, dv.start} !== 66'b0 ||
        {dv.dividend, dv.divisor} !== 64'b0) begin
      errors++;
      $display("FAIL reset_vals: hi=%h lo=%h done=%b st=%b dd=%h ds=%h want all 0",
               hi, lo, done, dv.start, dv.dividend, dv.divisor);
    end
    op_valid = 1'b0;
    rt_val   = '0;
    reset    = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_divu();
    int s0;
    bit sok;
    s0 = start_cnt;
    drive_op(1'b0, 32'd100, 32'd7);
    wait_done(sok);
    vectors++;
    if (!sok) begin
      errors++;
      $display("FAIL divu_stall: stall profile wrong, want 1 until DONE");
    end
    vectors++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL divu_start: pulses=%0d want 1",
               start_cnt - s0);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL divu_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_div_signed();
    bit sok;
    drive_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(sok);
    vectors++;
    if (dv.dividend !== 32'd100 || dv.divisor !== 32'd7) begin
      errors++;
      $display("FAIL div_mag: dd=%h ds=%h want 00000064 00000007",
               dv.dividend, dv.divisor);
    end
    drive_op(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done(sok);
    drive_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(sok);
    vectors++;
    if (dv.dividend !== 32'h8000_0000 || dv.divisor !== 32'd1) begin
      errors++;
      $display("FAIL div_min_mag: dd=%h ds=%h want 80000000 00000001",
               dv.dividend, dv.divisor);
    end
    drive_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(sok);
    vectors++;
    if (!sok) begin
      errors++;
      $display("FAIL div_signed_stall: stall profile wrong");
    end
    @(negedge clock);
  endtask

  task automatic test_div_zero();
    int s0;
    s0 = start_cnt;
    drive_op(1'b0, 32'd5, 32'd0);
    vectors++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5 ||
        done !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL divzero: lo=%h hi=%h done=%b stall=%b want ffffffff 00000005 1 0",
               lo, hi, done, stall);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (start_cnt != s0 || dv.start !== 1'b0) begin
      errors++;
      $display("FAIL divzero_start: pulses=%0d want 0",
               start_cnt - s0);
    end
  endtask

  task automatic test_mt();
    logic [31:0] lsave;
    bit sok;
    lsave = lo;
    mthi  = 1'b1;
    wdata = 32'h1234;
    @(posedge clock);
    #1;
    mthi = 1'b0;
    vectors++;
    if (hi !== 32'h1234 || lo !== lsave) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h want 00001234 %h",
               hi, lo, lsave);
    end
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'd77;
    @(posedge clock);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    vectors++;
    if (hi !== 32'd77 || lo !== 32'd77) begin
      errors++;
      $display("FAIL mthilo: hi=%h lo=%h want 0000004d x2",
               hi, lo);
    end
    drive_op(1'b0, 32'd50, 32'd5);
    wait_busy();
    lsave = lo;
    mtlo  = 1'b1;
    wdata = 32'hDEAD;
    @(posedge clock);
    #1;
    mtlo = 1'b0;
    vectors++;
    if (lo !== lsave) begin
      errors++;
      $display("FAIL mtlo_run: lo=%h want %h", lo, lsave);
    end
    wait_done(sok);
    @(negedge clock);
    lsave = lo;
    mtlo  = 1'b1;
    wdata = 32'hBEEF;
    drive_op(1'b0, 32'd81, 32'd9);
    mtlo = 1'b0;
    vectors++;
    if (lo !== lsave) begin
      errors++;
      $display("FAIL mtlo_op: lo=%h want %h", lo, lsave);
    end
    wait_done(sok);
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bit sok;
    drive_op(1'b0, 32'd1000, 32'd3);
    wait_busy();
    reset    = 1'b1;
    op_valid = 1'b1;
    rt_val   = 32'd5;
    @(posedge clock);
    #1;
    exp_q.delete();
    vectors++;
    if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 ||
        done !== 1'b0 || dv.start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: stall=%b hi=%h lo=%h done=%b want 0",
               stall, hi, lo, done);
    end
    op_valid = 1'b0;
    rt_val   = '0;
    reset    = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: stall=%b done=%b want 0 0",
               stall, done);
    end
    drive_op(1'b0, 32'd9, 32'd3);
    wait_done(sok);
    vectors++;
    if (!sok) begin
      errors++;
      $display("FAIL reset_after_stall: stall profile wrong");
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    bit sok;
    drive_op(1'b1, 32'hFFFF_FFEC, 32'd3);
    wait_done(sok);
    drive_op(1'b0, 32'd17, 32'd4);
    vectors++;
    if (dv.start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: div_start=%b want 1", dv.start);
    end
    wait_done(sok);
    vectors++;
    if (!sok) begin
      errors++;
      $display("FAIL b2b_stall: stall profile wrong");
    end
  endtask

  task automatic test_random();
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    bit          sok;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = 32'($urandom_range(1, 20));
        4: begin a = 32'h8000_0000; b = $urandom | 32'd1; end
        default: b = $urandom | 32'h10;
      endcase
      drive_op(s, a, b);
      if (b != 0) begin
        wait_done(sok);
        vectors++;
        if (!sok) begin
          errors++;
          $display("FAIL rand_stall: op %0d stall profile wrong", i);
        end
      end
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_mt();
    test_reset_mid();
    test_back_to_back();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding want 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
